sim_fetch_req: RTL
==================

# sim_fetch_req

Fetch-side requester for the `sim_intf` instruction-supply interface. It drives `pc_try` each cycle and consumes the same-cycle `miss`/`pc_factual`/`insn` response. On a hit it buffers `{pc, insn}` into an output FIFO and advances sequentially. On a miss it re-steers to the PC the simulator reports. It sits between `sim_intf` and the downstream decode stage, and accepts redirects from that stage.

## Interface
Parameters:
- `RESET_PC`, default `64'h0`: value of `pc_try` after reset.
- `DEPTH`, default 4: output FIFO entries; power of two, at least 2.
- `MAX_MISS`, default 3: consecutive misses tolerated before the block halts with an error.

Ports:
- `clk`  in  1  sole clock; all state updates on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  fetch enable; level-sensitive.
- `pc_try`  out  64  PC presented to `sim_intf`; registered.
- `pc_factual`  in  64  PC the simulator actually holds; valid when `miss`=1.
- `insn`  in  32  instruction at `pc_try`; valid when `miss`=0.
- `miss`  in  1  same-cycle response: `pc_try` ≠ simulator PC.
- `redir_valid`  in  1  downstream redirect request.
- `redir_pc`  in  64  redirect target.
- `out_valid`  out  1  FIFO head valid.
- `out_ready`  in  1  downstream accepts head.
- `out_pc`  out  64  head PC.
- `out_insn`  out  32  head instruction.
- `miss_cnt`  out  32  total misses taken, saturating.
- `err`  out  1  sticky; set on miss-loop overflow.

## Operation
- States: IDLE, FETCH, HALT.
  - IDLE → FETCH when `en`=1.
  - FETCH → IDLE when `en`=0.
  - FETCH → HALT on overflow (below).
  - HALT is left only by `rst`.
- A response is consumed only in FETCH, when the FIFO is not full (`count` < `DEPTH`) and `redir_valid`=0. In every other cycle the response is ignored and `pc_try` holds its value.
- Hit (`miss`=0, consumed): push `{pc_try, insn}`; next cycle `pc_try` = `pc_try`+4, mod 2^64 (wraps); `miss_run` clears.
- Miss (`miss`=1, consumed): no push; next cycle `pc_try` = `pc_factual`; `miss_cnt`++ (saturates at `32'hFFFFFFFF`); `miss_run`++.
  - If `miss_run` reaches `MAX_MISS` with this miss: set `err`, enter HALT. `pc_try` still updates.
- Redirect (`redir_valid`=1, any state except HALT):
  - FIFO flushed (count 0, `out_valid` 0 next cycle).
  - `pc_try` = `redir_pc` next cycle; `miss_run` clears.
  - Redirect has priority over the response and over a same-cycle pop.
- Priority: `rst` > redirect > response.
- FIFO is full-only stall: when `count`=`DEPTH` no push occurs, even if a pop happens the same cycle.
- Pop occurs when `out_valid`=1 and `out_ready`=1.
- Push and pop in the same cycle, with count below `DEPTH`: count unchanged.
- HALT: no pushes, FIFO keeps draining, redirects ignored.
- Reset values:
  - `pc_try` = `RESET_PC`.
  - `out_valid`=0, `miss_cnt`=0, `err`=0, `miss_run`=0.
  - State IDLE, FIFO empty.
  - `out_pc`/`out_insn` = 0.
- Reset asserted mid-operation discards FIFO contents and any in-flight response in that cycle.

## Timing
- `pc_try` is a flop output; the `sim_intf` response is combinational from it and sampled at the next posedge.
- Hit latency: `pc_try`=P in cycle N with a hit → `out_valid`=1 and `out_pc`=P in cycle N+1 (FIFO was empty); `pc_try`=P+4 in N+1.
- Miss: `pc_try`=`pc_factual` in N+1. The earliest push of that target is in N+1, visible at the output in N+2.
- Redirect in cycle N → `pc_try`=`redir_pc` and `out_valid`=0 in N+1.
- `out_*` are driven from FIFO storage/pointers only; there is no combinational path from `out_ready` or `miss` to any output.
- Sustained throughput: 1 instruction/cycle while hits continue and `out_ready`=1.

## Test plan
- Reset, `en`=1, `RESET_PC`=`'h1000`; simulator hits at `1000`, `1004`, `1008`, `100C`, `out_ready`=1 → `out_pc` sequence `1000`/`1004`/`1008`/`100C` one per cycle; `miss_cnt`=0.
- `pc_try`=`1008`, simulator holds `AAAA1008` → miss; next cycle `pc_try`=`AAAA1008`, no push, `miss_cnt`=1; hit follows with `out_pc`=`AAAA1008`.
- `MAX_MISS`=3; simulator misses at `1010`, `CCCC1010`, `DDDD1010` in succession → after the third miss `err`=1, state HALT, no further pushes; only `rst` clears `err`.
- `out_ready`=0 with continuous hits, `DEPTH`=4 → four pushes, then `pc_try` holds at `RESET_PC`+16. Raise `out_ready` → entries drain in order; fetch resumes at `+16` one cycle after count drops below 4.
- FIFO holding 3 entries, `redir_valid`=1, `redir_pc`=`'h2000`, `out_ready`=1, `miss`=1 in the same cycle → next cycle `out_valid`=0, `pc_try`=`2000`, `miss_cnt` unchanged.
- `pc_try`=`FFFFFFFFFFFFFFFC` with a hit → next `pc_try`=`0`. Assert `rst` mid-stream with 2 entries buffered → next cycle `out_valid`=0, `pc_try`=`RESET_PC`, state IDLE.

Source files
------------

// File: rtl/sim_fetch_req.sv
// Fetch requester for sim_intf: presents pc_try, buffers hits into a small FIFO,
// re-steers on misses and accepts flushing redirects from decode.
module sim_fetch_req #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          DEPTH    = 4,
  parameter int          MAX_MISS = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [63:0] pc_try,
  input  logic [63:0] pc_factual,
  input  logic [31:0] insn,
  input  logic        miss,
  input  logic        redir_valid,
  input  logic [63:0] redir_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_pc,
  output logic [31:0] out_insn,
  output logic [31:0] miss_cnt,
  output logic        err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [31:0] MAX_MISS_W = 32'(MAX_MISS);

  typedef enum logic [1:0] {IDLE, FETCH, HALT} state_t;

  state_t          state_reg;
  logic [63:0]     pc_reg;
  logic [95:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]     count_reg;
  logic [31:0]     miss_cnt_reg, miss_run_reg;
  logic            err_reg;
  logic [95:0]     head;

  logic full, redir_take, consume, push, pop, overflow;

  always_comb begin
    full       = (count_reg == DEPTH_W);
    redir_take = redir_valid && (state_reg != HALT);
    // The response is only meaningful when nothing outranks it this cycle.
    consume    = (state_reg == FETCH) && en && !full && !redir_valid;
    push       = consume && !miss;
    pop        = (count_reg != '0) && out_ready;
    overflow   = consume && miss && ((miss_run_reg + 32'd1) >= MAX_MISS_W);
  end

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem[wr_ptr_reg] <= {pc_reg, insn};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      pc_reg       <= RESET_PC;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      miss_cnt_reg <= '0;
      miss_run_reg <= '0;
      err_reg      <= 1'b0;
    end else begin
      if (redir_take) begin
        pc_reg       <= redir_pc;
        miss_run_reg <= '0;
        wr_ptr_reg   <= '0;
        rd_ptr_reg   <= '0;
        count_reg    <= '0;
      end else begin
        if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
        if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        case ({push, pop})
          2'b10:   count_reg <= count_reg + 1'b1;
          2'b01:   count_reg <= count_reg - 1'b1;
          default: count_reg <= count_reg;
        endcase
        if (consume) begin
          if (miss) begin
            pc_reg       <= pc_factual;
            miss_run_reg <= miss_run_reg + 32'd1;
            if (miss_cnt_reg != '1) miss_cnt_reg <= miss_cnt_reg + 32'd1;
            if (overflow) err_reg <= 1'b1;
          end else begin
            pc_reg       <= pc_reg + 64'd4;
            miss_run_reg <= '0;
          end
        end
      end

      case (state_reg)
        IDLE:    if (en) state_reg <= FETCH;
        FETCH:   if (overflow) state_reg <= HALT;
                 else if (!en) state_reg <= IDLE;
        default: state_reg <= HALT;
      endcase
    end
  end

  // Head is read straight from storage; gated so an empty FIFO shows zeros.
  assign head      = mem[rd_ptr_reg];
  assign out_valid = (count_reg != '0);
  assign out_pc    = out_valid ? head[95:32] : 64'h0;
  assign out_insn  = out_valid ? head[31:0]  : 32'h0;
  assign pc_try    = pc_reg;
  assign miss_cnt  = miss_cnt_reg;
  assign err       = err_reg;

endmodule
